counter_sequencer: RTL
======================

# counter_sequencer

Programmable run controller for the 6-bit counter datapath. It holds a configuration (terminal value, direction, one-shot or continuous mode) and sequences a synchronous up/down count through start, hold, resume and abort. It reports terminal events to the surrounding logic as single-cycle `done` and `wrap` pulses. It replaces free-running ripple counting with a controlled, single-clock counter that other blocks can start and stop.

## Interface
- `WIDTH`, default 6: counter and limit width in bits.
- `DEFAULT_LIMIT`, default 63: terminal value loaded at reset.
- `clk`  in  1: single system clock, rising edge active.
- `clear`  in  1: reset, asynchronous and active-high, one clock, as decided for this block.
- `start`  in  1: launch from IDLE/DONE; resume from HOLD.
- `halt`  in  1: freeze the count (RUN→HOLD); abort to IDLE (HOLD→IDLE).
- `cfg_we`  in  1: configuration write strobe.
- `cfg_limit`  in  WIDTH: terminal value.
- `cfg_down`  in  1: 1 = count down from limit to 0; 0 = count up from 0 to limit.
- `cfg_oneshot`  in  1: 1 = stop at terminal; 0 = wrap and continue.
- `count`  out  WIDTH: current count, registered.
- `state`  out  2: IDLE=00, RUN=01, HOLD=10, DONE=11.
- `busy`  out  1: 1 in RUN or HOLD.
- `done`  out  1: one-cycle pulse on entry to DONE.
- `wrap`  out  1: one-cycle pulse on a continuous-mode wrap.

## Operation
- Reset (`clear`=1, any time, including mid-count) forces:
  - `count`=0, `state`=IDLE, `busy`=0, `done`=0, `wrap`=0.
  - limit=`DEFAULT_LIMIT`, down=0, oneshot=0.
- Start value (SV) is 0 when up, limit when down. Terminal value (TV) is limit when up, 0 when down.
- Configuration:
  - `cfg_we` is accepted only in IDLE or DONE. In RUN or HOLD it is ignored, with no partial update.
  - `cfg_we` and `start` on the same edge: the new config is stored and that start uses it.
- IDLE:
  - `start` → RUN, `count`←SV.
  - `halt` alone has no effect.
- RUN, evaluated on each edge in priority order:
  1. `halt` → HOLD, count unchanged. `halt` beats `start` and beats terminal detection.
  2. If `count`==TV:
     - oneshot: → DONE, count stays TV, `done`=1 next cycle.
     - continuous: `count`←SV, stay in RUN, `wrap`=1 next cycle.
  3. Otherwise `count`←`count`±1.
- HOLD:
  - `halt` → IDLE, `count`←0. `halt` has priority over `start`.
  - Else `start` → RUN, count continues from the held value.
  - Else stay, count frozen.
- DONE:
  - `start` → RUN, `count`←SV.
  - Else stay, count held at TV.
  - `halt` has no effect.
- Arithmetic is modulo 2^WIDTH. The block never steps past TV, so no natural overflow occurs.
- If the limit is changed so that a held count lies beyond TV, the change cannot take effect: config is locked while busy.
- Limit 0:
  - Up mode reaches terminal on the first RUN edge.
  - Continuous up with limit 0 keeps `count`=0 and pulses `wrap` every cycle.

## Timing
- All outputs are registered and change only on `clk` rising edge or on `clear` assertion.
- `start` sampled at edge N → `count`=SV and `busy`=1 after edge N. First step after edge N+1.
- Up, limit L, one-shot:
  - start at edge N gives `count`=k after edge N+k.
  - DONE is entered at edge N+L+1. `done` is high for exactly one cycle after that edge.
- Continuous period is L+1 cycles. `wrap` is high for the cycle in which `count`=SV follows TV.
- `done` and `wrap` never assert in the same cycle and are never high for two consecutive cycles, except when limit=0 in continuous mode.
- `busy` drops in the same cycle that `done` rises.

## Test plan
- Reset: assert `clear` for 2 cycles mid-RUN at `count`=17 → immediately `count`=0, `state`=00, `busy`=0. `cfg_limit` reads back as 63 (verified by an up one-shot run ending at 63).
- Up one-shot: write limit=5, down=0, oneshot=1, then pulse `start` → `count` 0,1,2,3,4,5, then state=11 with `done` pulsed once, `count` held at 5 for 10 more cycles.
- Down continuous: limit=3, down=1, oneshot=0 → `count` 3,2,1,0,3,2… with `wrap` high on each return to 3, period 4 cycles.
- Hold/resume/abort:
  - Halt at `count`=4 (limit 10, up) → count frozen 5 cycles.
  - `start` → continues 5,6…
  - Second halt, then `halt` in HOLD → `state`=00, `count`=0.
- Config lock and simultaneity:
  - `cfg_we` with limit=2 during RUN → ignored, run ends at the old limit.
  - `cfg_we`+`start` on the same edge in DONE → new limit used.
  - `halt`+`start` together in RUN → HOLD.
- Limit 0 edge case: up, continuous → `count` stays 0, `wrap` high every cycle. One-shot → DONE one edge after start.

Source files
------------

// File: rtl/counter_sequencer.sv
// Programmable start/hold/resume/abort controller for a synchronous up/down
// counter with one-shot or continuous terminal handling.
module counter_sequencer #(
  parameter int WIDTH         = 6,
  parameter int DEFAULT_LIMIT = 63
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             halt,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_down,
  input  logic             cfg_oneshot,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_LIMIT);

  state_t           st;
  logic [WIDTH-1:0] limit;
  logic             down;
  logic             oneshot;

  logic             cfg_ok;
  logic [WIDTH-1:0] e_limit;
  logic             e_down;
  logic [WIDTH-1:0] sv;
  logic [WIDTH-1:0] tv;
  logic [WIDTH-1:0] step;

  // A config write on the same edge as start must steer that start.
  always_comb begin
    cfg_ok  = cfg_we && (st == IDLE || st == DONE);
    e_limit = cfg_ok ? cfg_limit : limit;
    e_down  = cfg_ok ? cfg_down : down;
    sv      = e_down ? e_limit : '0;
    tv      = down ? '0 : limit;
    step    = down ? count - ONE : count + ONE;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      st      <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      limit   <= DEF;
      down    <= 1'b0;
      oneshot <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (cfg_ok) begin
        limit   <= cfg_limit;
        down    <= cfg_down;
        oneshot <= cfg_oneshot;
      end
      unique case (st)
        IDLE: begin
          if (start) begin
            st    <= RUN;
            count <= sv;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            st <= HOLD;
          end else if (count == tv) begin
            if (oneshot) begin
              st   <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              count <= sv;
              wrap  <= 1'b1;
            end
          end else begin
            count <= step;
          end
        end
        HOLD: begin
          if (halt) begin
            st    <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (start) begin
            st <= RUN;
          end
        end
        DONE: begin
          if (start) begin
            st    <= RUN;
            count <= sv;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign state = st;

endmodule
